// File: rtl/sumador_sat.sv
// ============================================================================
// Module   : sumador_sat
// Brief    : Registered signed 2N-bit adder with overflow detection.
//            Define SUMADOR_SAT_EN to clamp overflowing results to the
//            most-positive / most-negative value; otherwise results wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_sat #(
  parameter int N = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2*N-1:0]  Multiplica,
  input  logic [2*N-1:0]  Sum_ext,
  output logic [2*N-1:0]  Suma_G,
  output logic            out_valid,
  output logic            ovf,
  output logic            ovf_sticky
);

  localparam int W = 2 * N;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W:0]   sum_full;
  logic         overflow;
  logic [W-1:0] result;

  // One guard bit: the two top bits disagree only when same-sign operands
  // produce a result of the opposite sign.
  assign sum_full = {Multiplica[W-1], Multiplica} + {Sum_ext[W-1], Sum_ext};
  assign overflow = sum_full[W] ^ sum_full[W-1];

`ifdef SUMADOR_SAT_EN
  always_comb begin
    result = sum_full[W-1:0];
    if (overflow) begin
      result = sum_full[W] ? MAX_NEG : MAX_POS;
    end
  end
`else
  always_comb begin
    result = sum_full[W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      Suma_G     <= '0;
      out_valid  <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Suma_G <= result;
        ovf    <= overflow;
        if (overflow) begin
          ovf_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sumador_sat.sv
// Randomized scoreboard bench for sumador_sat against an integer-arithmetic
// reference model; honours SUMADOR_SAT_EN the same way as the design.
`default_nettype none

module tb_sumador_sat;

  localparam int N = 24;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] mult;
  logic [W-1:0] sext;
  logic [W-1:0] suma;
  logic         out_valid;
  logic         ovf;
  logic         ovf_sticky;

  sumador_sat #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .Multiplica(mult),
    .Sum_ext   (sext),
    .Suma_G    (suma),
    .out_valid (out_valid),
    .ovf       (ovf),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
    logic         sticky;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic         sticky_m;
  logic [W-1:0] last_sum;
  logic         last_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer sum of the two signed operands, then clamp or wrap.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_, s, maxv, minv;
    sa   = longint'($signed(a));
    sb_  = longint'($signed(b));
    s    = sa + sb_;
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    e.ovf = (s > maxv) || (s < minv);
    e.sum = s[W-1:0];
`ifdef SUMADOR_SAT_EN
    if (s > maxv) e.sum = maxv[W-1:0];
    if (s < minv) e.sum = minv[W-1:0];
`endif
    e.sticky = 1'b0;
    e.due = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Biased operands so both overflow directions and their edges occur often.
  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] maxp;
    maxp = {1'b0, {(W-1){1'b1}}};
    case ($urandom_range(0, 3))
      0: return rnd48();
      1: return maxp - W'($urandom_range(0, 15));
      2: return ~maxp + W'($urandom_range(0, 15));
      default: return W'($urandom_range(0, 255)) - W'(128);
    endcase
  endfunction

  // Called at posedge+1; applies one valid sample and returns at the next posedge+1.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    mult = a;
    sext = b;
    in_valid = 1'b1;
    e = model(a, b);
    sticky_m = sticky_m | e.ovf;
    e.sticky = sticky_m;
    e.due = cyc + 1;
    sb.push_back(e);
    last_sum = e.sum;
    last_ovf = e.ovf;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares whenever the DUT presents a result.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("Suma_G", 64'(suma), 64'(e.sum));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("ovf_sticky", 64'(ovf_sticky), 64'(e.sticky));
      end
    end
  end

  initial begin
    logic [W-1:0] maxp, minn;
    maxp = {1'b0, {(W-1){1'b1}}};
    minn = {1'b1, {(W-1){1'b0}}};
    sticky_m = 1'b0;
    last_sum = '0;
    last_ovf = 1'b0;

    // Reset held for two edges while valid data is presented.
    rst = 1'b1;
    in_valid = 1'b1;
    mult = maxp;
    sext = 48'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_Suma_G", 64'(suma), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_ovf_sticky", 64'(ovf_sticky), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors.
    drive(48'h000000000005, 48'h000000000003);
    drive(48'hFFFFFFFFFFFE, 48'h000000000001);
    drive(48'h000000000000, 48'h000000000000);
    drive(48'h7FFFFFFFFFFF, 48'h000000000001);
    drive(48'h800000000000, 48'hFFFFFFFFFFFF);
    drive(maxp, minn);
    drive(maxp, maxp);
    drive(minn, minn);

    // Back-to-back random stream.
    for (int i = 0; i < 5000; i++) begin
      drive(rnd_op(), rnd_op());
    end

    // Idle: outputs must hold while inputs keep changing.
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      mult = rnd48();
      sext = rnd48();
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd0);
      chk("hold_Suma_G", 64'(suma), 64'(last_sum));
      chk("hold_ovf", 64'(ovf), 64'(last_ovf));
      chk("hold_ovf_sticky", 64'(ovf_sticky), 64'(sticky_m));
    end
    @(posedge clk);
    #1;

    // Guarantee sticky is set, then reset mid-stream with a sample in flight.
    drive(maxp, 48'h2);
    mult = maxp;
    sext = maxp;
    in_valid = 1'b1;
    rst = 1'b1;
    sticky_m = 1'b0;
    @(negedge clk);
    chk("midrst_ovf_sticky_before", 64'(ovf_sticky), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_Suma_G", 64'(suma), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    chk("midrst_ovf_sticky", 64'(ovf_sticky), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    drive(48'h10, 48'h20);
    drive(minn, 48'hFFFFFFFFFFFF);
    drive(48'h1, 48'h1);
    in_valid = 1'b0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sumador_sat.md
Name: sumador_sat

Overview:
- Registered, signed, two's-complement adder for the fixed-point datapath.
- Sums the product from the upstream multiplier (Multiplica) with an external/accumulated term (Sum_ext) and produces a 2N-bit result Suma_G.
- Sits directly after the multiplier stage; its output feeds the accumulator/output register of the filter chain.
- Overflow is detected; the result is saturated or wrapped depending on a compile-time option.

Parameters:
- N, 24, base word width; all data ports are 2N bits (48 by default), signed two's-complement.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies Multiplica/Sum_ext this cycle.
- Multiplica  input  2N  signed product operand.
- Sum_ext  input  2N  signed external addend.
- Suma_G  output  2N  signed registered sum.
- out_valid  output  1  Suma_G updated this cycle.
- ovf  output  1  overflow occurred on the sample currently presented on Suma_G.
- ovf_sticky  output  1  latched overflow since last reset.

Behaviour:
- One clock, one synchronous active-high reset. On rst=1 at a rising edge: Suma_G=0, out_valid=0, ovf=0, ovf_sticky=0. Reset has priority over in_valid in the same cycle.
- Latency is exactly 1 cycle. in_valid=1 at edge k gives the result on Suma_G and out_valid=1 after edge k; throughput is one sample per cycle with no stall.
- When in_valid=0: Suma_G and ovf hold their previous values and out_valid=0.
- Arithmetic:
  - Compute a 2N+1-bit sign-extended sum S = Multiplica + Sum_ext.
  - Overflow when S[2N] != S[2N-1], i.e. both operands have the same sign and the result sign differs.
- Positive overflow: ovf=1, and Suma_G = 2^(2N-1)-1 if saturation is enabled.
- Negative overflow: ovf=1, and Suma_G = -2^(2N-1) if saturation is enabled.
- No overflow: Suma_G = S[2N-1:0], ovf=0.
- ovf_sticky is set whenever a valid sample overflows and is cleared only by rst.
- Mixed-sign operands can never overflow. Zero plus zero gives zero.
- Reset asserted mid-stream: the in-flight sample is discarded, and outputs return to reset values on the next edge.
- No latches. All outputs are driven from flops.

Optional Feature:
- Macro SUMADOR_SAT_EN.
- Defined: overflow results clamp to the most-positive or most-negative value as above.
- Undefined: overflow results wrap modulo 2^(2N), so Suma_G = S[2N-1:0].
- ovf and ovf_sticky behave identically in both builds; only the Suma_G value differs.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and arbitrary data -> Suma_G=0, out_valid=0, ovf=0, ovf_sticky=0.
- Basic sum: Multiplica=0x000000000005, Sum_ext=0x000000000003, in_valid=1 -> next cycle Suma_G=0x000000000008, out_valid=1, ovf=0.
- Signed sum: Multiplica=0xFFFFFFFFFFFE (-2), Sum_ext=0x000000000001 -> Suma_G=0xFFFFFFFFFFFF (-1), ovf=0.
- Positive overflow: Multiplica=0x7FFFFFFFFFFF, Sum_ext=0x000000000001 ->
  - with SUMADOR_SAT_EN: Suma_G=0x7FFFFFFFFFFF;
  - without it: Suma_G=0x800000000000;
  - both builds: ovf=1, ovf_sticky=1.
- Negative overflow: Multiplica=0x800000000000, Sum_ext=0xFFFFFFFFFFFF ->
  - with SUMADOR_SAT_EN: Suma_G=0x800000000000;
  - without it: Suma_G=0x7FFFFFFFFFFF;
  - both builds: ovf=1.
- Streaming: drive 5000 random operand pairs back-to-back, then deassert in_valid -> each result matches the reference model one cycle later; Suma_G holds after the last sample; ovf_sticky stays set after any overflow until rst.
